exec_stage_reg_p: RTL and testbench
===================================

Name: exec_stage_reg_p

Overview:
- Parametrised decode-to-execute pipeline register for the pipelined Y86 core; next generation of the fixed-width execute register.
- Adds asynchronous active-low reset, stall (hold), bubble (NOP injection) with defined priority, source-register forwarding fields, and a sticky exception-halt state.
- Adds a control-conflict flag and optional performance counters.
- Sits between the decode stage and the ALU/execute stage, driven by the pipeline control unit.

Parameters:
- DATA_W, 64, width of valC/valA/valB
- REG_W, 4, register-ID width
- STAT_W, 2, status width
- NOP_ICODE, 4'h1, icode loaded on bubble/reset
- RNONE, 4'hF, "no register" ID
- STAT_AOK, 2'b00, normal status
- STAT_BUB, 2'b11, bubble status
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- d_icode  in  4  decoded icode
- d_ifun  in  4  decoded ifun
- d_valC  in  DATA_W  constant word
- d_valA  in  DATA_W  operand A (signed)
- d_valB  in  DATA_W  operand B (signed)
- d_destE, d_destM, d_srcA, d_srcB  in  REG_W each  register IDs
- d_status  in  STAT_W  decode status
- E_stall  in  1  hold current contents
- E_bubble  in  1  load NOP bubble
- E_icode, E_ifun  out  4 each
- E_valC, E_valA, E_valB  out  DATA_W (valA/valB signed)
- E_destE, E_destM, E_srcA, E_srcB  out  REG_W each
- E_status  out  STAT_W
- E_valid  out  1  1 = holds a real, non-bubble instruction
- E_halted  out  1  sticky exception-halt indicator
- E_ctrl_err  out  1  sticky: stall and bubble requested together
- E_bubble_cnt, E_stall_cnt  out  CNT_W  performance counters

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-stall or halted):
  - E_icode=NOP_ICODE, E_ifun=0, E_valC/E_valA/E_valB=0.
  - All four register-ID outputs=RNONE.
  - E_status=STAT_BUB.
  - E_valid=0, E_halted=0, E_ctrl_err=0, both counters=0.
  - State=RUN.
- State machine, two states, RUN and HALTED.
- RUN, at each rising edge; priority bubble > stall > load:
  - E_bubble=1: load the reset bundle (NOP, zeros, RNONE, STAT_BUB), E_valid<=0.
  - E_stall=1 (no bubble): all outputs hold.
  - Neither asserted: all d_* fields load, E_valid<=(d_status!=STAT_BUB).
- RUN->HALTED: on the edge that loads a d_status that is neither STAT_AOK nor STAT_BUB (HLT/ADR/INS).
  - The excepting instruction is captured normally and E_halted<=1 on that same edge.
  - Bubble or stall on that edge: no capture, no transition.
- HALTED: all data/status outputs frozen regardless of E_stall, E_bubble or d_*. E_valid holds. Exit only via reset.
- Conflict: E_stall and E_bubble both high on an edge in RUN sets E_ctrl_err<=1 (sticky until reset); the bubble still wins. Ignored in HALTED.
- Latency: one cycle from d_* to E_* on a load edge. No combinational path from inputs to outputs.
- Width rules: d_valA/d_valB/d_valC pass bit-exact; no sign extension or truncation.

Optional Feature:
- Macro: EXEC_STAGE_PERF_CNT_EN.
- Defined, in RUN only:
  - E_bubble_cnt increments on each edge where a bubble is loaded.
  - E_stall_cnt increments on each edge where stall alone holds the register.
  - Both saturate at all-ones (no wrap).
  - Both freeze in HALTED.
  - Both clear on reset.
- Undefined: no counter flops; both outputs tied to 0.

Test Plan:
- Reset mid-load: d_icode=4'h6, d_valA=64'h5, rst_n pulsed low between edges -> outputs go to reset bundle immediately (before next clk), E_status=2'b11, E_destE=4'hF.
- Normal load: d_icode=4'h6, d_ifun=0, d_valA=-3, d_valB=7, d_srcA=2, d_destE=3, status AOK -> next edge E_valA=64'hFFFF_FFFF_FFFF_FFFD, E_valB=7, E_srcA=2, E_destE=3, E_valid=1.
- Stall then bubble: load icode 4'h3; 2 cycles E_stall=1 with d_icode=4'h6 -> E_icode stays 4'h3. Then E_bubble=1 -> E_icode=4'h1, E_valid=0. With EXEC_STAGE_PERF_CNT_EN: E_stall_cnt=2, E_bubble_cnt=1.
- Conflict: E_stall=1 and E_bubble=1 same edge -> bubble loaded, E_ctrl_err=1, and it stays 1 after the inputs drop.
- Exception halt: load d_status=2'b01 with d_icode=4'h0 -> E_halted=1. Next 3 edges loading icode 4'h6 or E_bubble=1 leave E_icode=4'h0, E_status=2'b01. rst_n low clears E_halted.
- Counter saturation (CNT_W=4, macro defined): 20 consecutive bubble edges -> E_bubble_cnt=4'hF and stays there.

Source files
------------

// File: rtl/exec_stage_reg_p.sv
// ---------------------------------------------------------------------------
// exec_stage_reg_p
// Decode-to-execute pipeline register for the pipelined Y86 core.
//
// Each rising edge in RUN does one of three things, in priority order:
//   bubble : load a NOP bundle (NOP_ICODE, zero data, RNONE IDs, STAT_BUB)
//   stall  : hold every output
//   load   : capture the d_* bundle
// Loading an excepting status (neither AOK nor BUB) captures that
// instruction and moves to HALTED. HALTED freezes everything until rst_n.
//
// Ports
//   clk, rst_n              rising-edge clock, async active-low reset
//   d_icode .. d_status     decoded instruction bundle from decode
//   E_stall, E_bubble       pipeline control requests
//   E_icode .. E_status     registered bundle towards execute
//   E_valid                 1 = real, non-bubble instruction held
//   E_halted                sticky exception-halt indicator
//   E_ctrl_err              sticky: stall and bubble requested together
//   E_bubble_cnt            bubble edges seen (saturating)
//   E_stall_cnt             stall-only edges seen (saturating)
//
// Optional feature macro: EXEC_STAGE_PERF_CNT_EN
//   defined   -> saturating performance counters are built
//   undefined -> no counter flops, both counter outputs tied to 0
// ---------------------------------------------------------------------------
module exec_stage_reg_p #(
    parameter int                DATA_W    = 64,
    parameter int                REG_W     = 4,
    parameter int                STAT_W    = 2,
    parameter logic [3:0]        NOP_ICODE = 4'h1,
    parameter logic [REG_W-1:0]  RNONE     = 4'hF,
    parameter logic [STAT_W-1:0] STAT_AOK  = 2'b00,
    parameter logic [STAT_W-1:0] STAT_BUB  = 2'b11,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        d_icode,
    input  logic [3:0]        d_ifun,
    input  logic [DATA_W-1:0] d_valC,
    input  logic [DATA_W-1:0] d_valA,
    input  logic [DATA_W-1:0] d_valB,
    input  logic [REG_W-1:0]  d_destE,
    input  logic [REG_W-1:0]  d_destM,
    input  logic [REG_W-1:0]  d_srcA,
    input  logic [REG_W-1:0]  d_srcB,
    input  logic [STAT_W-1:0] d_status,
    input  logic              E_stall,
    input  logic              E_bubble,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [REG_W-1:0]  E_destE,
    output logic [REG_W-1:0]  E_destM,
    output logic [REG_W-1:0]  E_srcA,
    output logic [REG_W-1:0]  E_srcB,
    output logic [STAT_W-1:0] E_status,
    output logic              E_valid,
    output logic              E_halted,
    output logic              E_ctrl_err,
    output logic [CNT_W-1:0]  E_bubble_cnt,
    output logic [CNT_W-1:0]  E_stall_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state, state_next;

    logic do_bubble;   // load the NOP bundle this edge
    logic do_load;     // capture the d_* bundle this edge
    logic conflict;    // stall and bubble both requested while running

    // Status values other than AOK and BUB (HLT/ADR/INS) stop the pipeline.
    logic exc_status;
    assign exc_status = (d_status != STAT_AOK) && (d_status != STAT_BUB);

    // State register.
    // NOTE: every clocked block uses non-blocking (<=) so all flops sample
    // the same pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // Next-state and per-edge action decode.
    // NOTE: every output of this block gets a default first; a path that
    // forgot to assign one would otherwise infer a latch.
    always_comb begin
        state_next = state;
        do_bubble  = 1'b0;
        do_load    = 1'b0;
        conflict   = 1'b0;
        if (state == RUN) begin
            if (E_bubble) begin
                do_bubble = 1'b1;
                conflict  = E_stall;
            end else if (!E_stall) begin
                do_load = 1'b1;
                if (exc_status) state_next = HALTED;
            end
        end
    end

    // Payload and status register. A stall, or the HALTED state, simply
    // leaves every flop untouched.
    // NOTE: the whole bundle is reset (not just E_valid) because execute
    // decodes icode/IDs directly and must see a clean NOP out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            E_icode  <= NOP_ICODE;
            E_ifun   <= 4'h0;
            E_valC   <= '0;
            E_valA   <= '0;
            E_valB   <= '0;
            E_destE  <= RNONE;
            E_destM  <= RNONE;
            E_srcA   <= RNONE;
            E_srcB   <= RNONE;
            E_status <= STAT_BUB;
            E_valid  <= 1'b0;
        end else if (do_bubble) begin
            E_icode  <= NOP_ICODE;
            E_ifun   <= 4'h0;
            E_valC   <= '0;
            E_valA   <= '0;
            E_valB   <= '0;
            E_destE  <= RNONE;
            E_destM  <= RNONE;
            E_srcA   <= RNONE;
            E_srcB   <= RNONE;
            E_status <= STAT_BUB;
            E_valid  <= 1'b0;
        end else if (do_load) begin
            E_icode  <= d_icode;
            E_ifun   <= d_ifun;
            E_valC   <= d_valC;
            E_valA   <= d_valA;
            E_valB   <= d_valB;
            E_destE  <= d_destE;
            E_destM  <= d_destM;
            E_srcA   <= d_srcA;
            E_srcB   <= d_srcB;
            E_status <= d_status;
            E_valid  <= (d_status != STAT_BUB);
        end
    end

    // Sticky control-conflict flag; only set while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        E_ctrl_err <= 1'b0;
        else if (conflict) E_ctrl_err <= 1'b1;
    end

    // The halt indicator is the state itself: it rises on the same edge that
    // captures the excepting instruction.
    assign E_halted = (state == HALTED);

`ifdef EXEC_STAGE_PERF_CNT_EN
    // Stall-only edges: the register held because of stall, not a bubble.
    logic stall_only;
    assign stall_only = (state == RUN) && E_stall && !E_bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            E_bubble_cnt <= '0;
            E_stall_cnt  <= '0;
        end else begin
            if (do_bubble && (E_bubble_cnt != {CNT_W{1'b1}}))
                E_bubble_cnt <= E_bubble_cnt + CNT_W'(1);
            if (stall_only && (E_stall_cnt != {CNT_W{1'b1}}))
                E_stall_cnt <= E_stall_cnt + CNT_W'(1);
        end
    end
`else
    assign E_bubble_cnt = '0;
    assign E_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_exec_stage_reg_p.sv
// ---------------------------------------------------------------------------
// tb_exec_stage_reg_p
// Directed bench for exec_stage_reg_p: a vector table for single-edge
// behaviour plus hand-written sequences for reset, conflict, saturation and
// exception halt. A second instance with CNT_W=4 shares all inputs so the
// counter saturation corner can be reached in a handful of edges.
// ---------------------------------------------------------------------------
module tb_exec_stage_reg_p;

`ifdef EXEC_STAGE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dest_e;
        logic [3:0]  dest_m;
        logic [3:0]  src_a;
        logic [3:0]  src_b;
        logic [1:0]  status;
    } bundle_t;

    typedef struct {
        string   name;
        logic    stall;
        logic    bubble;
        bundle_t in;
        bundle_t exp;
        logic    exp_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  d_icode, d_ifun;
    logic [63:0] d_valC, d_valA, d_valB;
    logic [3:0]  d_destE, d_destM, d_srcA, d_srcB;
    logic [1:0]  d_status;
    logic        E_stall, E_bubble;

    logic [3:0]  E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_destE, E_destM, E_srcA, E_srcB;
    logic [1:0]  E_status;
    logic        E_valid, E_halted, E_ctrl_err;
    logic [15:0] E_bubble_cnt, E_stall_cnt;

    logic [3:0]  s_icode, s_ifun;
    logic [63:0] s_valC, s_valA, s_valB;
    logic [3:0]  s_destE, s_destM, s_srcA, s_srcB;
    logic [1:0]  s_status;
    logic        s_valid, s_halted, s_ctrl_err;
    logic [3:0]  s_bubble_cnt, s_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    exec_stage_reg_p u_dut (
        .clk(clk), .rst_n(rst_n),
        .d_icode(d_icode), .d_ifun(d_ifun),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
        .d_destE(d_destE), .d_destM(d_destM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .d_status(d_status), .E_stall(E_stall), .E_bubble(E_bubble),
        .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_destE(E_destE), .E_destM(E_destM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .E_status(E_status), .E_valid(E_valid), .E_halted(E_halted),
        .E_ctrl_err(E_ctrl_err),
        .E_bubble_cnt(E_bubble_cnt), .E_stall_cnt(E_stall_cnt)
    );

    exec_stage_reg_p #(.CNT_W(4)) u_dut_small (
        .clk(clk), .rst_n(rst_n),
        .d_icode(d_icode), .d_ifun(d_ifun),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
        .d_destE(d_destE), .d_destM(d_destM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .d_status(d_status), .E_stall(E_stall), .E_bubble(E_bubble),
        .E_icode(s_icode), .E_ifun(s_ifun),
        .E_valC(s_valC), .E_valA(s_valA), .E_valB(s_valB),
        .E_destE(s_destE), .E_destM(s_destM), .E_srcA(s_srcA), .E_srcB(s_srcB),
        .E_status(s_status), .E_valid(s_valid), .E_halted(s_halted),
        .E_ctrl_err(s_ctrl_err),
        .E_bubble_cnt(s_bubble_cnt), .E_stall_cnt(s_stall_cnt)
    );

    function automatic bundle_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                                   input logic [63:0] valc, input logic [63:0] vala,
                                   input logic [63:0] valb, input logic [3:0] dest_e,
                                   input logic [3:0] dest_m, input logic [3:0] src_a,
                                   input logic [3:0] src_b, input logic [1:0] status);
        bundle_t b;
        b.icode = icode;   b.ifun = ifun;
        b.valc = valc;     b.vala = vala;     b.valb = valb;
        b.dest_e = dest_e; b.dest_m = dest_m;
        b.src_a = src_a;   b.src_b = src_b;
        b.status = status;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bundle(input string tag, input bundle_t exp);
        check({tag, ".icode"},  64'(E_icode),  64'(exp.icode));
        check({tag, ".ifun"},   64'(E_ifun),   64'(exp.ifun));
        check({tag, ".valC"},   E_valC,        exp.valc);
        check({tag, ".valA"},   E_valA,        exp.vala);
        check({tag, ".valB"},   E_valB,        exp.valb);
        check({tag, ".destE"},  64'(E_destE),  64'(exp.dest_e));
        check({tag, ".destM"},  64'(E_destM),  64'(exp.dest_m));
        check({tag, ".srcA"},   64'(E_srcA),   64'(exp.src_a));
        check({tag, ".srcB"},   64'(E_srcB),   64'(exp.src_b));
        check({tag, ".status"}, 64'(E_status), 64'(exp.status));
    endtask

    task automatic drive(input logic stall, input logic bubble, input bundle_t b);
        E_stall  = stall;
        E_bubble = bubble;
        d_icode  = b.icode;  d_ifun  = b.ifun;
        d_valC   = b.valc;   d_valA  = b.vala;  d_valB = b.valb;
        d_destE  = b.dest_e; d_destM = b.dest_m;
        d_srcA   = b.src_a;  d_srcB  = b.src_b;
        d_status = b.status;
    endtask

    // One rising edge, then settle 1 ns so outputs are sampled off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    vec_t    vecs[7];
    bundle_t nop_b, a_b, b_b, x_b, c_b, d_b, h_b, e_b;

    initial begin
        nop_b = mk(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 2'b11);
        a_b   = mk(4'h6, 4'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h7,
                   4'h3, 4'hF, 4'h2, 4'hF, 2'b00);
        b_b   = mk(4'h3, 4'h0, 64'h1234, 64'h5, 64'h9, 4'hF, 4'h4, 4'h1, 4'h2, 2'b00);
        x_b   = mk(4'h6, 4'h2, 64'hAA, 64'h11, 64'h22, 4'h5, 4'h6, 4'h7, 4'h8, 2'b00);
        c_b   = mk(4'h2, 4'h5, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0000,
                   64'h7FFF_FFFF_FFFF_FFFF, 4'hE, 4'hF, 4'h0, 4'h9, 2'b11);
        d_b   = mk(4'hC, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'hDEAD_BEEF_CAFE_F00D, 4'h0, 4'h1, 4'hE, 4'hD, 2'b00);
        h_b   = mk(4'h0, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 2'b01);
        e_b   = mk(4'h0, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF, 2'b10);

        //          name          stall bubble in    exp    valid
        vecs[0] = '{"load_neg",    1'b0, 1'b0, a_b,  a_b,   1'b1};
        vecs[1] = '{"load_b",      1'b0, 1'b0, b_b,  b_b,   1'b1};
        vecs[2] = '{"stall1",      1'b1, 1'b0, x_b,  b_b,   1'b1};
        vecs[3] = '{"stall2",      1'b1, 1'b0, x_b,  b_b,   1'b1};
        vecs[4] = '{"bubble",      1'b0, 1'b1, x_b,  nop_b, 1'b0};
        vecs[5] = '{"load_bubst",  1'b0, 1'b0, c_b,  c_b,   1'b0};
        vecs[6] = '{"load_ones",   1'b0, 1'b0, d_b,  d_b,   1'b1};

        // Power-on reset, released between edges.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, a_b);
        #12;
        check_bundle("por", nop_b);
        check("por.valid",  64'(E_valid),    64'd0);
        check("por.halted", 64'(E_halted),   64'd0);
        check("por.ctrl",   64'(E_ctrl_err), 64'd0);
        rst_n = 1'b1;

        // Reset mid-load: outputs return to the NOP bundle before the next edge.
        drive(1'b0, 1'b0, mk(4'h6, 4'h0, 64'h0, 64'h5, 64'h0,
                             4'h3, 4'hF, 4'h1, 4'hF, 2'b00));
        step();
        check("midld.icode_loaded", 64'(E_icode), 64'h6);
        #2;
        rst_n = 1'b0;
        #1;
        check_bundle("midrst", nop_b);
        check("midrst.valid", 64'(E_valid), 64'd0);
        rst_n = 1'b1;

        // Table-driven single-edge behaviour.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].stall, vecs[i].bubble, vecs[i].in);
            step();
            check_bundle(vecs[i].name, vecs[i].exp);
            check({vecs[i].name, ".valid"}, 64'(E_valid), 64'(vecs[i].exp_valid));
        end
        check("tbl.bubble_cnt", 64'(E_bubble_cnt), PERF ? 64'd1 : 64'd0);
        check("tbl.stall_cnt",  64'(E_stall_cnt),  PERF ? 64'd2 : 64'd0);
        check("tbl.halted",     64'(E_halted),     64'd0);
        check("tbl.ctrl_err",   64'(E_ctrl_err),   64'd0);

        // Conflict: bubble wins, flag is sticky.
        drive(1'b1, 1'b1, x_b);
        step();
        check_bundle("conf", nop_b);
        check("conf.valid", 64'(E_valid),    64'd0);
        check("conf.err",   64'(E_ctrl_err), 64'd1);
        drive(1'b0, 1'b0, a_b);
        step();
        check("conf.after_icode", 64'(E_icode),      64'h6);
        check("conf.err_sticky",  64'(E_ctrl_err),   64'd1);
        check("conf.bubble_cnt",  64'(E_bubble_cnt), PERF ? 64'd2 : 64'd0);
        check("conf.stall_cnt",   64'(E_stall_cnt),  PERF ? 64'd2 : 64'd0);

        // Excepting status presented under bubble or stall: no capture, no halt.
        drive(1'b0, 1'b1, h_b);
        step();
        check("excbub.halted", 64'(E_halted), 64'd0);
        check("excbub.icode",  64'(E_icode),  64'h1);
        drive(1'b1, 1'b0, e_b);
        step();
        check("excstl.halted", 64'(E_halted), 64'd0);
        check("excstl.status", 64'(E_status), 64'h3);

        // Counter saturation on the CNT_W=4 instance.
        pulse_reset();
        check("sat.rst_cnt",   64'(s_bubble_cnt), 64'd0);
        check("sat.rst_err",   64'(E_ctrl_err),   64'd0);
        drive(1'b0, 1'b1, x_b);
        repeat (14) step();
        check("sat.cnt14",  64'(s_bubble_cnt), PERF ? 64'd14 : 64'd0);
        repeat (6) step();
        check("sat.cnt20",  64'(s_bubble_cnt), PERF ? 64'hF  : 64'd0);
        check("sat.wide20", 64'(E_bubble_cnt), PERF ? 64'd20 : 64'd0);
        check("sat.stall0", 64'(s_stall_cnt),  64'd0);

        // Exception halt: capture, then freeze against load/bubble/conflict.
        pulse_reset();
        drive(1'b0, 1'b0, h_b);
        step();
        check("halt.halted", 64'(E_halted), 64'd1);
        check_bundle("halt.cap", h_b);
        check("halt.valid",  64'(E_valid),  64'd1);
        for (int k = 0; k < 3; k++) begin
            drive(k == 2, k != 0, x_b);
            step();
            check("halt.frz_icode",  64'(E_icode),      64'h0);
            check("halt.frz_status", 64'(E_status),     64'h1);
            check("halt.frz_valA",   E_valA,            64'h0);
            check("halt.frz_valid",  64'(E_valid),      64'd1);
            check("halt.frz_halted", 64'(E_halted),     64'd1);
            check("halt.frz_err",    64'(E_ctrl_err),   64'd0);
            check("halt.frz_bcnt",   64'(E_bubble_cnt), 64'd0);
            check("halt.frz_scnt",   64'(E_stall_cnt),  64'd0);
        end
        rst_n = 1'b0;
        #1;
        check("halt.rst_halted", 64'(E_halted), 64'd0);
        check("halt.rst_icode",  64'(E_icode),  64'h1);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, b_b);
        step();
        check("halt.resume_icode", 64'(E_icode), 64'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
